divuint_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `divuint` unsigned divider among `NUM_REQ` requesters in the Timekeeper datapath. The block accepts per-requester operand pairs and sequences the divider's enable/busy/done handshake for one request at a time. It returns quotient, remainder and status on a shared response bus with a one-hot response strobe. It replaces the free-running retrigger loop with demand-driven issue and adds a watchdog timeout.

---
 rtl/divuint_arb.sv | 183 ++++++++++++++++++
 tb/tb_divuint_arb.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divuint_arb.sv
// Round-robin arbiter that shares one divuint divider among NUM_REQ requesters.
// Sequences the divider's enable/busy/done handshake per grant and returns results with a watchdog.
module divuint_arb #(
   parameter int unsigned DATA_WIDTH = 10,
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] a_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] b_i,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic [NUM_REQ-1:0]            rsp_valid_o,
   output logic [DATA_WIDTH-1:0]         rsp_quot_o,
   output logic [DATA_WIDTH-1:0]         rsp_rem_o,
   output logic                          rsp_dbz_o,
   output logic                          rsp_err_o,
   output logic                          busy_o,
   output logic                          div_enable_o,
   output logic [DATA_WIDTH-1:0]         div_a_o,
   output logic [DATA_WIDTH-1:0]         div_b_o,
   input  logic                          div_busy_i,
   input  logic                          div_done_i,
   input  logic                          div_valid_i,
   input  logic                          div_dbz_i,
   input  logic [DATA_WIDTH-1:0]         div_quot_i,
   input  logic [DATA_WIDTH-1:0]         div_rem_i
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);
   localparam int unsigned CntW = $clog2(TIMEOUT);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_REQ - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e                  state_q, state_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
   logic [IdxW-1:0]         last_q, last_d;
   logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [DATA_WIDTH-1:0]   quot_q, quot_d, rem_q, rem_d;
   logic                    dbz_q, dbz_d, err_q, err_d;
   logic                    busy_q, busy_d, en_q, en_d;
   logic [CntW-1:0]         cnt_q, cnt_d;

   logic                    pick_found;
   logic [IdxW-1:0]         pick_idx;
   logic [DATA_WIDTH-1:0]   pick_a, pick_b;
   int unsigned             cand;

   // Search upward from last+1 so the previous owner has lowest priority.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = last_q;
      pick_a     = '0;
      pick_b     = '0;
      cand       = 0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = (32'(last_q) + i) % NUM_REQ;
         if (!pick_found && req_i[IdxW'(cand)]) begin
            pick_found = 1'b1;
            pick_idx   = IdxW'(cand);
            pick_a     = a_i[cand*DATA_WIDTH +: DATA_WIDTH];
            pick_b     = b_i[cand*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rsp_valid_d = '0;
      last_d      = last_q;
      a_d         = a_q;
      b_d         = b_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      dbz_d       = dbz_q;
      err_d       = err_q;
      en_d        = 1'b0;
      cnt_d       = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               grant_d = NUM_REQ'(1) << pick_idx;
               last_d  = pick_idx;
               a_d     = pick_a;
               b_d     = pick_b;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (!div_busy_i) begin
               en_d    = 1'b1;
               cnt_d   = '0;
               state_d = StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q + 1'b1;
            // A done seen while our own enable is still high belongs to nothing we issued.
            if (div_done_i && !en_q) begin
               rsp_valid_d = grant_q;
               state_d     = StResp;
               quot_d      = '0;
               rem_d       = '0;
               dbz_d       = 1'b0;
               err_d       = 1'b0;
               if (div_dbz_i) begin
                  dbz_d = 1'b1;
               end else if (div_valid_i) begin
                  quot_d = div_quot_i;
                  rem_d  = div_rem_i;
               end else begin
                  err_d = 1'b1;
               end
            end else if (cnt_q == CntLast) begin
               rsp_valid_d = grant_q;
               state_d     = StResp;
               quot_d      = '0;
               rem_d       = '0;
               dbz_d       = 1'b0;
               err_d       = 1'b1;
            end
         end
         StResp: begin
            grant_d = '0;
            state_d = StIdle;
         end
         default: begin
            grant_d = '0;
            state_d = StIdle;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         grant_q     <= '0;
         rsp_valid_q <= '0;
         last_q      <= IdxLast;
         a_q         <= '0;
         b_q         <= '0;
         quot_q      <= '0;
         rem_q       <= '0;
         dbz_q       <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         en_q        <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rsp_valid_q <= rsp_valid_d;
         last_q      <= last_d;
         a_q         <= a_d;
         b_q         <= b_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         dbz_q       <= dbz_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         en_q        <= en_d;
         cnt_q       <= cnt_d;
      end
   end

   assign grant_o      = grant_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_quot_o   = quot_q;
   assign rsp_rem_o    = rem_q;
   assign rsp_dbz_o    = dbz_q;
   assign rsp_err_o    = err_q;
   assign busy_o       = busy_q;
   assign div_enable_o = en_q;
   assign div_a_o      = a_q;
   assign div_b_o      = b_q;

endmodule

// File: tb/tb_divuint_arb.sv
// Directed-plus-random bench for divuint_arb with a behavioural divider and round-robin model.
module tb_divuint_arb;

   localparam int unsigned DW = 10;
   localparam int unsigned NR = 4;
   localparam int unsigned TO = 64;

   typedef logic [1:0] idx_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req;
   logic [NR*DW-1:0] a_i, b_i;
   logic [NR-1:0]   grant_o, rsp_valid_o;
   logic [DW-1:0]   rsp_quot_o, rsp_rem_o, div_a_o, div_b_o;
   logic            rsp_dbz_o, rsp_err_o, busy_o, div_enable_o;
   logic            div_busy, div_done, div_valid, div_dbz;
   logic [DW-1:0]   div_quot, div_rem;

   // divider model controls
   int              dlat;
   int              div_mode;    // 0 normal, 1 never completes, 2 done without valid/dbz
   logic            extra_done;
   int              pend;
   logic            m_done;
   logic [DW-1:0]   m_a, m_b;

   int              n_vec = 0;
   int              n_err = 0;
   int              en_pulses = 0;
   int              strobes = 0;
   idx_t            last_m;
   logic [DW-1:0]   a_v [NR];
   logic [DW-1:0]   b_v [NR];

   always #5 clk = ~clk;

   divuint_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req),
      .a_i          (a_i),
      .b_i          (b_i),
      .grant_o      (grant_o),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_quot_o   (rsp_quot_o),
      .rsp_rem_o    (rsp_rem_o),
      .rsp_dbz_o    (rsp_dbz_o),
      .rsp_err_o    (rsp_err_o),
      .busy_o       (busy_o),
      .div_enable_o (div_enable_o),
      .div_a_o      (div_a_o),
      .div_b_o      (div_b_o),
      .div_busy_i   (div_busy),
      .div_done_i   (div_done),
      .div_valid_i  (div_valid),
      .div_dbz_i    (div_dbz),
      .div_quot_i   (div_quot),
      .div_rem_i    (div_rem)
   );

   // Divider: samples enable, raises done dlat edges after it samples the start.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend   <= 0;
         m_done <= 1'b0;
         m_a    <= '0;
         m_b    <= '0;
      end else begin
         m_done <= 1'b0;
         if (div_enable_o) begin
            m_a  <= div_a_o;
            m_b  <= div_b_o;
            pend <= (div_mode == 1) ? 0 : dlat + 1;
         end else if (pend == 1) begin
            m_done <= 1'b1;
            pend   <= 0;
         end else if (pend > 1) begin
            pend <= pend - 1;
         end
      end
   end

   assign div_done  = m_done | extra_done;
   assign div_valid = m_done && (div_mode == 0) && (m_b != '0);
   assign div_dbz   = m_done && (div_mode == 0) && (m_b == '0);
   assign div_quot  = (m_b != '0) ? m_a / m_b : '1;
   assign div_rem   = (m_b != '0) ? m_a % m_b : '1;

   always @(posedge clk) begin
      if (div_enable_o) en_pulses <= en_pulses + 1;
      if (rsp_valid_o != '0) strobes <= strobes + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_strobe(input int limit, output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (rsp_valid_o == '0 && cyc < limit);
   endtask

   task automatic set_ops(input idx_t k, input logic [DW-1:0] a, input logic [DW-1:0] b);
      a_v[k] = a;
      b_v[k] = b;
      a_i[k*DW +: DW] = a;
      b_i[k*DW +: DW] = b;
   endtask

   function automatic idx_t rr_pick(input idx_t last, input logic [NR-1:0] r);
      idx_t c;
      for (int i = 1; i <= int'(NR); i++) begin
         c = last + idx_t'(i);
         if (r[c]) return c;
      end
      return last;
   endfunction

   task automatic chk_rsp(input string tag, input idx_t k, input logic [DW-1:0] q,
                          input logic [DW-1:0] r, input logic dbz, input logic err);
      chk({tag, ".valid"}, 32'(rsp_valid_o), 32'(4'b0001 << k));
      chk({tag, ".grant"}, 32'(grant_o), 32'(4'b0001 << k));
      chk({tag, ".quot"}, 32'(rsp_quot_o), 32'(q));
      chk({tag, ".rem"}, 32'(rsp_rem_o), 32'(r));
      chk({tag, ".dbz"}, 32'(rsp_dbz_o), 32'(dbz));
      chk({tag, ".err"}, 32'(rsp_err_o), 32'(err));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".grant"}, 32'(grant_o), 0);
      chk({tag, ".valid"}, 32'(rsp_valid_o), 0);
      chk({tag, ".quot"}, 32'(rsp_quot_o), 0);
      chk({tag, ".rem"}, 32'(rsp_rem_o), 0);
      chk({tag, ".dbz"}, 32'(rsp_dbz_o), 0);
      chk({tag, ".err"}, 32'(rsp_err_o), 0);
      chk({tag, ".busy"}, 32'(busy_o), 0);
      chk({tag, ".en"}, 32'(div_enable_o), 0);
      chk({tag, ".div_a"}, 32'(div_a_o), 0);
      chk({tag, ".div_b"}, 32'(div_b_o), 0);
   endtask

   initial begin
      int   cyc, e0, s0;
      idx_t k;
      logic [DW-1:0] ra, rb;

      rst_n = 1'b0; req = '0; a_i = '0; b_i = '0;
      div_busy = 1'b0; extra_done = 1'b0; div_mode = 0; dlat = 5;
      last_m = idx_t'(NR - 1);
      for (int i = 0; i < int'(NR); i++) set_ops(idx_t'(i), '0, '0);
      step(3);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      step(2);

      // Single request on requester 1, 100/7 with a 5-cycle divider.
      set_ops(2'd1, 10'd100, 10'd7);
      dlat = 5;
      e0 = en_pulses;
      req = 4'b0010;
      wait_strobe(40, cyc);
      k = rr_pick(last_m, req);
      chk("single.latency", 32'(cyc), 32'(1 + 3 + dlat));
      chk_rsp("single", k, 10'd14, 10'd2, 1'b0, 1'b0);
      last_m = k;
      req = '0;
      step(1);
      chk("single.en_once", 32'(en_pulses - e0), 1);
      chk("single.strobe_1cyc", 32'(rsp_valid_o), 0);
      chk("single.grant_clr", 32'(grant_o), 0);
      chk("single.quot_held", 32'(rsp_quot_o), 14);
      chk("single.idle", 32'(busy_o), 0);
      step(1);

      // All requesters held: round-robin with random operands and divider latency.
      for (int i = 0; i < int'(NR); i++)
         set_ops(idx_t'(i), DW'($urandom_range(0, 1023)), DW'($urandom_range(1, 1023)));
      s0 = strobes;
      dlat = $urandom_range(0, 6);
      req = 4'b1111;
      for (int r = 0; r < 6; r++) begin
         k = rr_pick(last_m, req);
         wait_strobe(200, cyc);
         chk_rsp("rr", k, a_v[k] / b_v[k], a_v[k] % b_v[k], 1'b0, 1'b0);
         last_m = k;
         set_ops(k, DW'($urandom_range(0, 1023)), DW'($urandom_range(1, 1023)));
         dlat = $urandom_range(0, 6);
      end
      req = '0;
      step(2);
      chk("rr.strobe_count", 32'(strobes - s0), 6);

      // Divide by zero on requester 2.
      set_ops(2'd2, DW'($urandom_range(1, 1023)), '0);
      req = 4'b0100;
      k = rr_pick(last_m, req);
      wait_strobe(100, cyc);
      chk_rsp("dbz", k, '0, '0, 1'b1, 1'b0);
      last_m = k;
      req = '0;
      step(2);

      // Divider never completes: watchdog abort, then a late done is ignored.
      div_mode = 1;
      set_ops(2'd0, DW'($urandom_range(0, 1023)), DW'($urandom_range(1, 1023)));
      req = 4'b0001;
      k = rr_pick(last_m, req);
      wait_strobe(200, cyc);
      chk("timeout.latency", 32'(cyc), 32'(TO + 2));
      chk_rsp("timeout", k, '0, '0, 1'b0, 1'b1);
      last_m = k;
      req = '0;
      step(1);
      s0 = strobes;
      step(8);
      extra_done = 1'b1;
      step(1);
      extra_done = 1'b0;
      step(3);
      chk("late_done.no_strobe", 32'(strobes - s0), 0);
      chk("late_done.idle", 32'(busy_o), 0);
      chk("late_done.err_held", 32'(rsp_err_o), 1);
      div_mode = 0;
      set_ops(2'd3, DW'($urandom_range(0, 1023)), DW'($urandom_range(1, 1023)));
      req = 4'b1000;
      k = rr_pick(last_m, req);
      wait_strobe(100, cyc);
      chk_rsp("after_to", k, a_v[k] / b_v[k], a_v[k] % b_v[k], 1'b0, 1'b0);
      last_m = k;
      req = '0;
      step(2);

      // Divider busy for 20 cycles while in ISSUE.
      div_busy = 1'b1;
      set_ops(2'd1, DW'($urandom_range(0, 1023)), DW'($urandom_range(1, 1023)));
      e0 = en_pulses;
      req = 4'b0010;
      k = rr_pick(last_m, req);
      step(21);
      chk("busy.no_en", 32'(en_pulses - e0), 0);
      chk("busy.en_low", 32'(div_enable_o), 0);
      chk("busy.busy_o", 32'(busy_o), 1);
      div_busy = 1'b0;
      wait_strobe(100, cyc);
      chk("busy.en_once", 32'(en_pulses - e0), 1);
      chk_rsp("busy", k, a_v[k] / b_v[k], a_v[k] % b_v[k], 1'b0, 1'b0);
      last_m = k;
      req = '0;
      step(2);

      // Done with neither valid nor dbz.
      div_mode = 2;
      set_ops(2'd2, DW'($urandom_range(0, 1023)), DW'($urandom_range(1, 1023)));
      req = 4'b0100;
      k = rr_pick(last_m, req);
      wait_strobe(100, cyc);
      chk_rsp("invalid", k, '0, '0, 1'b0, 1'b1);
      last_m = k;
      div_mode = 0;
      req = '0;
      step(2);

      // Reset in WAIT aborts without a strobe; requester 0 wins afterwards.
      dlat = 30;
      set_ops(2'd2, DW'($urandom_range(0, 1023)), DW'($urandom_range(1, 1023)));
      req = 4'b0100;
      step(6);
      chk("rst_mid.in_wait", 32'(busy_o), 1);
      s0 = strobes;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_mid");
      last_m = idx_t'(NR - 1);
      step(2);
      chk("rst_mid.no_strobe", 32'(strobes - s0), 0);
      for (int i = 0; i < int'(NR); i++)
         set_ops(idx_t'(i), DW'($urandom_range(0, 1023)), DW'($urandom_range(1, 1023)));
      dlat = 3;
      req = 4'b1111;
      rst_n = 1'b1;
      k = rr_pick(last_m, req);
      wait_strobe(100, cyc);
      chk_rsp("post_rst", k, a_v[k] / b_v[k], a_v[k] % b_v[k], 1'b0, 1'b0);
      req = '0;
      step(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
